div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
Parametrised iterative integer divider, the successor to the unsigned-only divider. It adds a per-operation signed/unsigned mode, divide-by-zero and signed-overflow flags, and a one-cycle done pulse. It uses a restoring shift-subtract algorithm and produces one quotient bit per clock. It sits beside the ALU as the multi-cycle DIV/MOD execution unit, using a start/ready handshake.

Parameters:
N, 16, dividend and quotient width (N >= 2)
M, 16, divisor and remainder width (2 <= M <= N)
L, 5, iteration counter width; must satisfy 2^L > N

Ports:
clk  input  1  clock; all state changes on its rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request a new division; sampled only while ready=1
is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
word1  input  N  dividend; sampled with start
word2  input  M  divisor; sampled with start
quotient  output  N  registered quotient
remainder  output  M  registered remainder
ready  output  1  1 = idle; results valid and a new start is accepted
done  output  1  one-cycle pulse when results update
dbz  output  1  divide-by-zero flag for the last operation
ovf  output  1  signed overflow flag for the last operation

Behaviour:
- Reset: while reset=0, asynchronously forces state=IDLE. Outputs: quotient=0, remainder=0, ready=1, done=0, dbz=0, ovf=0, counter=0.
- Reset mid-operation aborts the division immediately. No done pulse is produced.
- States: IDLE, DIV, FIX.
- IDLE (ready=1), with start=1 at edge E0:
  - Latch is_signed.
  - Latch |word1| and |word2| as magnitudes; absolute values are taken only when is_signed=1.
  - Latch the sign of the quotient (sign1 XOR sign2) and the sign of the remainder (sign1).
  - Clear the partial remainder. Load counter=N. ready drops after E0.
  - If word2==0: go to FIX with a dbz pending. Otherwise go to DIV.
  - If is_signed=1, word1 = -2^(N-1) and word2 = all-ones: go to FIX with an ovf pending.
- DIV: each edge performs one restoring step.
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor using an (M+1)-bit compare.
  - If non-negative, keep the difference and shift in quotient bit 1; else shift in 0.
  - Decrement the counter. When it reaches 0, the next state is FIX. DIV lasts exactly N edges.
- FIX: one edge.
  - Normal case: negate the quotient magnitude if quotient sign=1; negate the remainder magnitude if remainder sign=1 (signed mode only).
  - Register quotient, remainder, dbz and ovf. Assert done=1 for that cycle and ready=1. Return to IDLE.
- Latency, normal case: start sampled at E0; results, ready=1 and done=1 appear after edge E0+N+1 (N+2 cycles, 18 for N=16).
- Latency, dbz/ovf: results appear after E0+1.
- Rounding: signed results truncate toward zero. The remainder takes the sign of the dividend. word1 = quotient*word2 + remainder always holds, except when dbz=1.
- Divide-by-zero: quotient = all-ones, remainder = word1[M-1:0], dbz=1, ovf=0.
- Signed overflow: quotient = -2^(N-1) (0x8000 for N=16), remainder=0, ovf=1, dbz=0.
- Outputs and flags hold their values until the next FIX. They are never cleared in IDLE.
- start while ready=0 is ignored; no queueing.
- Inputs are don't-care except at the start-sampling edge.
- start held high continuously: a new operation begins on the first IDLE edge after each FIX, so back-to-back operations are separated by one ready cycle.
- A zero dividend or a dividend smaller than the divisor takes the full N iterations; there is no early exit.
- Width rule for unsigned mode with M<N: the remainder fits in M bits; the quotient uses all N bits.

Test Plan:
- Unsigned, N=M=16: word1=1000, word2=7 -> quotient=142, remainder=6, dbz=ovf=0; done pulses exactly 18 cycles after the start edge.
- Signed: word1=0xFFF9 (-7), word2=0x0002 -> quotient=0xFFFD (-3), remainder=0xFFFF (-1). Then word1=7, word2=0xFFFE -> quotient=0xFFFD, remainder=0x0001.
- Divide by zero: word1=0x1234, word2=0, unsigned -> after 2 edges quotient=0xFFFF, remainder=0x1234, dbz=1. The next valid op clears dbz.
- Signed overflow: word1=0x8000, word2=0xFFFF, is_signed=1 -> quotient=0x8000, remainder=0, ovf=1. The same operands unsigned -> quotient=0x0000, remainder=0x8000, ovf=0.
- Handshake: assert start again 5 cycles into an operation with different operands -> ignored, original result returned. Hold start high -> the second op starts on the cycle after done.
- Reset mid-op: drive reset=0 at cycle 8 of 0xFFFF/0x0001 -> immediately quotient=0, remainder=0, ready=1, no done pulse. After release, a fresh 0xFFFF/0x0001 gives quotient=0xFFFF, remainder=0.

Source files
------------

// File: rtl/div_unit_if.sv
// Start/ready handshake and result bus between a requester and the divider.
interface div_unit_if #(
  parameter int N = 16,
  parameter int M = 16
);
  logic         start;
  logic         is_signed;
  logic [N-1:0] word1;
  logic [M-1:0] word2;
  logic [N-1:0] quotient;
  logic [M-1:0] remainder;
  logic         ready;
  logic         done;
  logic         dbz;
  logic         ovf;

  // Requester side: issues operands, observes results and status.
  modport master (
    output start, is_signed, word1, word2,
    input  quotient, remainder, ready, done, dbz, ovf
  );

  // Divider side: consumes operands, drives results and status.
  modport slave (
    input  start, is_signed, word1, word2,
    output quotient, remainder, ready, done, dbz, ovf
  );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider, one quotient bit per clock, with signed/unsigned
// mode, divide-by-zero and signed-overflow detection and a one-cycle done pulse.
// L must satisfy 2^L > N so the iteration counter can hold N.
module div_unit #(
  parameter int N = 16,
  parameter int M = 16,
  parameter int L = 5
) (
  input  logic     clk,
  input  logic     reset,
  div_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

  state_t       state;
  state_t       state_next;

  logic [L-1:0] counter;
  logic [N-1:0] dvd;
  logic [M-1:0] prem;
  logic [M-1:0] dvs;
  logic         q_neg;
  logic         r_neg;
  logic         dbz_pend;
  logic         ovf_pend;

  logic [N-1:0] quotient_q;
  logic [M-1:0] remainder_q;
  logic         done_q;
  logic         dbz_q;
  logic         ovf_q;

  logic         ready_c;
  logic         load;
  logic         step;
  logic         finish;

  // Operand decode at the start-sampling edge. Signs only count in signed mode.
  logic         sign1;
  logic         sign2;
  logic         word2_zero;
  logic         ovf_hit;
  logic [N-1:0] mag1;
  logic [M-1:0] mag2;

  assign sign1      = bus.is_signed & bus.word1[N-1];
  assign sign2      = bus.is_signed & bus.word2[M-1];
  assign word2_zero = (bus.word2 == '0);
  assign ovf_hit    = bus.is_signed && (bus.word1 == {1'b1, {(N-1){1'b0}}})
                      && (bus.word2 == '1);
  assign mag1       = sign1 ? -bus.word1 : bus.word1;
  assign mag2       = sign2 ? -bus.word2 : bus.word2;

  // One restoring step: shift the next dividend bit into the partial remainder
  // and trial-subtract the divisor. Only the low M bits of the difference are
  // kept, which is exact whenever the subtraction does not go negative.
  logic [M:0]   shifted;
  logic [M-1:0] diff;
  logic         fits;

  assign shifted = {prem, dvd[N-1]};
  assign diff    = shifted[M-1:0] - dvs;
  assign fits    = (shifted >= {1'b0, dvs});

  // State register; reset aborts any division in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state: zero divisor and signed overflow bypass the iteration loop.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (word2_zero || ovf_hit) state_next = FIX;
          else                       state_next = DIV;
        end
      end
      DIV: begin
        if (counter == L'(1)) state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control decode from the current state.
  always_comb begin
    ready_c = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        load    = bus.start;
      end
      DIV:     step   = 1'b1;
      FIX:     finish = 1'b1;
      default: ready_c = 1'b0;
    endcase
  end

  // Datapath: operand latch, shift-subtract iterations and result fix-up.
  // On divide-by-zero the raw low dividend bits are parked in the partial
  // remainder so the fix-up can return them unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter     <= '0;
      dvd         <= '0;
      prem        <= '0;
      dvs         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dbz_pend    <= 1'b0;
      ovf_pend    <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      done_q <= finish;
      if (load) begin
        counter  <= L'(N);
        dvd      <= mag1;
        dvs      <= mag2;
        q_neg    <= sign1 ^ sign2;
        r_neg    <= sign1;
        dbz_pend <= word2_zero;
        ovf_pend <= ovf_hit;
        prem     <= word2_zero ? bus.word1[M-1:0] : '0;
      end else if (step) begin
        counter <= counter - L'(1);
        dvd     <= {dvd[N-2:0], fits};
        prem    <= fits ? diff : shifted[M-1:0];
      end else if (finish) begin
        if (dbz_pend) begin
          quotient_q  <= '1;
          remainder_q <= prem;
          dbz_q       <= 1'b1;
          ovf_q       <= 1'b0;
        end else if (ovf_pend) begin
          quotient_q  <= {1'b1, {(N-1){1'b0}}};
          remainder_q <= '0;
          dbz_q       <= 1'b0;
          ovf_q       <= 1'b1;
        end else begin
          quotient_q  <= q_neg ? -dvd : dvd;
          remainder_q <= r_neg ? -prem : prem;
          dbz_q       <= 1'b0;
          ovf_q       <= 1'b0;
        end
      end
    end
  end

  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.ready     = ready_c;
  assign bus.done      = done_q;
  assign bus.dbz       = dbz_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes hand-computed results, a
// monitor pops and compares them whenever done pulses.
module tb_div_unit;
  localparam int N = 16;
  localparam int M = 16;
  localparam int L = 5;
  localparam int LAT_FULL  = N + 1;
  localparam int LAT_SHORT = 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cycle = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    string       name;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
    int          edge_no;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  div_unit_if #(.N(N), .M(M)) bus();

  div_unit #(.N(N), .M(M), .L(L)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock and edge counter.
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done: got done=1 at edge %0d expected none", cycle);
      end else begin
        mon_e = sb.pop_front();
        check_output({mon_e.name, ".quotient"},  32'(bus.quotient),  32'(mon_e.q));
        check_output({mon_e.name, ".remainder"}, 32'(bus.remainder), 32'(mon_e.r));
        check_output({mon_e.name, ".dbz"},       32'(bus.dbz),       32'(mon_e.dbz));
        check_output({mon_e.name, ".ovf"},       32'(bus.ovf),       32'(mon_e.ovf));
        check_output({mon_e.name, ".ready"},     32'(bus.ready),     32'(1));
        check_output({mon_e.name, ".done_edge"}, 32'(cycle),         32'(mon_e.edge_no));
      end
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (bus.ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.ready !== 1'b1) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s.ready_timeout: got ready=%b expected 1", name, bus.ready);
    end
  endtask

  task automatic push_exp(input string name, input logic [15:0] q, input logic [15:0] r,
                          input logic edbz, input logic eovf, input int edge_no);
    exp_t e;
    e.name    = name;
    e.q       = q;
    e.r       = r;
    e.dbz     = edbz;
    e.ovf     = eovf;
    e.edge_no = edge_no;
    sb.push_back(e);
  endtask

  task automatic apply_stimulus(input string name, input logic [15:0] w1, input logic [15:0] w2,
                                input logic sgn, input logic [15:0] q, input logic [15:0] r,
                                input logic edbz, input logic eovf, input int lat);
    wait_ready(name);
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.word1     = w1;
    bus.word2     = w2;
    @(posedge clk);
    #1;
    push_exp(name, q, r, edbz, eovf, cycle + lat);
    @(negedge clk);
    bus.start     = 1'b0;
    bus.is_signed = 1'b1;
    bus.word1     = 16'hDEAD;
    bus.word2     = 16'h0000;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s.done_timeout: got %0d pending expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic run_op(input string name, input logic [15:0] w1, input logic [15:0] w2,
                        input logic sgn, input logic [15:0] q, input logic [15:0] r,
                        input logic edbz, input logic eovf, input int lat);
    apply_stimulus(name, w1, w2, sgn, q, r, edbz, eovf, lat);
    wait_drain(name);
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.word1     = '0;
    bus.word2     = '0;

    #12;
    check_output("reset.quotient",  32'(bus.quotient),  32'(0));
    check_output("reset.remainder", 32'(bus.remainder), 32'(0));
    check_output("reset.ready",     32'(bus.ready),     32'(1));
    check_output("reset.done",      32'(bus.done),      32'(0));
    check_output("reset.dbz",       32'(bus.dbz),       32'(0));
    check_output("reset.ovf",       32'(bus.ovf),       32'(0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_op("u_1000_7",      16'd1000,  16'd7,     1'b0, 16'd142,   16'd6,     1'b0, 1'b0, LAT_FULL);
    run_op("s_m7_2",        16'hFFF9,  16'h0002,  1'b1, 16'hFFFD,  16'hFFFF,  1'b0, 1'b0, LAT_FULL);
    run_op("s_7_m2",        16'h0007,  16'hFFFE,  1'b1, 16'hFFFD,  16'h0001,  1'b0, 1'b0, LAT_FULL);
    run_op("u_dbz",         16'h1234,  16'h0000,  1'b0, 16'hFFFF,  16'h1234,  1'b1, 1'b0, LAT_SHORT);
    run_op("u_after_dbz",   16'd100,   16'd10,    1'b0, 16'd10,    16'd0,     1'b0, 1'b0, LAT_FULL);
    run_op("s_ovf",         16'h8000,  16'hFFFF,  1'b1, 16'h8000,  16'h0000,  1'b0, 1'b1, LAT_SHORT);
    run_op("u_8000_ffff",   16'h8000,  16'hFFFF,  1'b0, 16'h0000,  16'h8000,  1'b0, 1'b0, LAT_FULL);
    run_op("s_m100_7",      16'hFF9C,  16'h0007,  1'b1, 16'hFFF2,  16'hFFFE,  1'b0, 1'b0, LAT_FULL);
    run_op("u_zero_dvd",    16'h0000,  16'h0005,  1'b0, 16'h0000,  16'h0000,  1'b0, 1'b0, LAT_FULL);
    run_op("u_small_dvd",   16'h0003,  16'hFFFF,  1'b0, 16'h0000,  16'h0003,  1'b0, 1'b0, LAT_FULL);
    run_op("u_ffff_1",      16'hFFFF,  16'h0001,  1'b0, 16'hFFFF,  16'h0000,  1'b0, 1'b0, LAT_FULL);
    run_op("s_dbz",         16'hFFF9,  16'h0000,  1'b1, 16'hFFFF,  16'hFFF9,  1'b1, 1'b0, LAT_SHORT);
    run_op("s_min_1",       16'h8000,  16'h0001,  1'b1, 16'h8000,  16'h0000,  1'b0, 1'b0, LAT_FULL);

    // A second start mid-operation must be ignored.
    apply_stimulus("hs_ignore", 16'd50000, 16'd300, 1'b0, 16'd166, 16'd200, 1'b0, 1'b0, LAT_FULL);
    repeat (4) @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.word1     = 16'd9;
    bus.word2     = 16'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain("hs_ignore");

    // Start held high: the second operation begins on the edge after done.
    wait_ready("b2b");
    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.word1     = 16'd1000;
    bus.word2     = 16'd7;
    @(posedge clk);
    #1;
    c0 = cycle;
    push_exp("b2b_first",  16'd142,  16'd6,    1'b0, 1'b0, c0 + LAT_FULL);
    push_exp("b2b_second", 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, c0 + LAT_FULL + 1 + LAT_FULL);
    @(negedge clk);
    bus.is_signed = 1'b1;
    bus.word1     = 16'hFFF9;
    bus.word2     = 16'h0002;
    repeat (LAT_FULL + 1) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain("b2b");

    // Reset mid-operation aborts with no done pulse.
    wait_ready("rst_mid");
    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.word1     = 16'hFFFF;
    bus.word2     = 16'h0001;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("rst_mid.quotient",  32'(bus.quotient),  32'(0));
    check_output("rst_mid.remainder", 32'(bus.remainder), 32'(0));
    check_output("rst_mid.ready",     32'(bus.ready),     32'(1));
    check_output("rst_mid.done",      32'(bus.done),      32'(0));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check_output("rst_mid.no_done_after", 32'(bus.done), 32'(0));

    run_op("rst_fresh", 16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, LAT_FULL);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
